freq_meter: RTL
===============

Name: freq_meter

Overview:
- Measures the frequency of a free-running, asynchronous square wave by counting its rising edges over a fixed gate window of system clocks.
- Typical sources are a ring-oscillator clock-divider output or any other untimed toggle source.
- Sits on the system clock domain. It publishes each edge count as a result word over a valid/ready handshake to a host, logger or UART formatter.

Parameters:
- GATE_CYCLES, 12000000, gate window length in clk cycles; legal range >= 4.
- CNT_W, 32, edge counter and result width.
- SYNC_STAGES, 2, synchronizer flops on osc_in; legal range >= 2.
- STALL_CYCLES, 1000000, no-edge timeout in clk cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous, active-low reset.
- osc_in  input  1  asynchronous oscillator input under measurement.
- en  input  1  measurement enable.
- result  output  CNT_W  rising-edge count of the last completed gate.
- result_ovf  output  1  edge count saturated during that gate.
- result_lost  output  1  a previous result was overwritten before it was consumed.
- result_valid  output  1  result fields hold an unconsumed measurement.
- result_ready  input  1  consumer accepts the result.
- busy  output  1  gate window in progress.
- stalled  output  1  optional; no osc_in edge for STALL_CYCLES.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - All synchronizer flops, the edge-detect previous bit, both counters, result, result_ovf, result_lost, result_valid, busy and stalled go to 0.
  - The FSM goes to IDLE.
  - Reset mid-gate discards the partial count.
- Synchronizer and edge detect:
  - osc_in passes through SYNC_STAGES flops; a rising edge is s & ~s_prev.
  - An osc_in rising edge is detected SYNC_STAGES+1 clk edges after it occurs.
  - osc_in high time and low time must each be >= 2 clk periods, so the measurable frequency is < f_clk/4. Faster inputs alias; this is not detected.
- FSM states are IDLE and GATE; busy=1 exactly in GATE.
- IDLE:
  - If en=1 → GATE, with gate_cnt=0 and edge_cnt=0.
  - Edges seen in IDLE are not counted.
- GATE, each cycle:
  - gate_cnt increments.
  - On a detected edge, edge_cnt increments, saturating at 2^CNT_W-1; saturation sets the internal ovf bit.
- Gate end, on the cycle where gate_cnt==GATE_CYCLES-1:
  - An edge detected in that cycle is included in the count.
  - Next cycle: result=edge_cnt(final), result_ovf=ovf, result_valid=1.
  - If en=1, the next gate starts in that same cycle with counters cleared, leaving no dead cycle between gates. If en=0 → IDLE.
- Abort: en=0 during GATE returns to IDLE next cycle, produces no result, and leaves the result registers untouched.
- Handshake:
  - result_valid stays 1 until a cycle with result_ready=1, then clears next cycle.
  - result fields are stable while result_valid=1 and no new load occurs.
- Overwrite rules:
  - New result while result_valid=1 and result_ready=0: fields are overwritten, result_lost=1, result_valid stays 1.
  - New result in the same cycle as result_ready=1: the old result is consumed, the new one is loaded, result_valid stays 1, result_lost=0.
  - result_lost otherwise clears when a result is consumed.

Optional Feature:
- Macro: FREQ_METER_STALL_EN.
- With the macro defined:
  - A stall counter clears on every detected edge and on reset; otherwise it increments, saturating at STALL_CYCLES.
  - stalled=1 while the counter equals STALL_CYCLES, independent of en and the FSM state.
  - stalled clears the cycle after the next detected edge.
- Without the macro: the stall counter is absent and stalled is tied to 0; the port remains.

Test Plan (all with GATE_CYCLES=100, CNT_W=8, SYNC_STAGES=2):
- osc_in period 10 clk, en=1, result_ready=1 → first result=10 (±1 for phase) with result_ovf=0; subsequent results are 10 each, one every 100 cycles, with no gaps.
- osc_in period 4 clk, CNT_W=4 → count saturates at 15, result=15, result_ovf=1.
- result_ready=0 across two gate ends → result_valid=1, second value held, result_lost=1; raise result_ready for one cycle → result_valid=0 and result_lost=0 next cycle.
- en dropped at gate cycle 50 → busy=0 next cycle, no result_valid pulse, result unchanged; re-raising en starts a fresh gate from 0.
- resetn=0 for one cycle mid-gate with result_valid=1 → all outputs 0 next cycle, FSM in IDLE.
- FREQ_METER_STALL_EN, STALL_CYCLES=50, osc_in held low → stalled=1 at about cycle 50; one osc_in edge → stalled=0 within SYNC_STAGES+2 cycles.

Source files
------------

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous osc_in over a
// window of GATE_CYCLES clk cycles and publishes each count on a
// valid/ready result port.
// Ports: clk, resetn (sync, active-low), osc_in (async), en;
//   result/result_ovf/result_lost/result_valid out, result_ready in;
//   busy (gate running), stalled (no osc_in edge for STALL_CYCLES).
// Optional macro FREQ_METER_STALL_EN adds the stall counter; without
//   it, stalled is tied to 0.
module freq_meter #(
   parameter int GATE_CYCLES  = 12000000,
   parameter int CNT_W        = 32,
   parameter int SYNC_STAGES  = 2,
   parameter int STALL_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             osc_in,
   input  logic             en,
   output logic [CNT_W-1:0] result,
   output logic             result_ovf,
   output logic             result_lost,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             busy,
   output logic             stalled
);

   localparam int GW = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {IDLE, GATE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [GW-1:0]          gate_q, gate_d;
   logic [CNT_W-1:0]       edge_q, edge_d;
   logic                   ovf_q, ovf_d;
   logic [CNT_W-1:0]       res_q, res_d;
   logic                   rovf_q, rovf_d;
   logic                   lost_q, lost_d;
   logic                   valid_q, valid_d;

   logic                   edge_det;
   logic [CNT_W-1:0]       edge_nxt;
   logic                   ovf_nxt;

   assign sync_d   = {sync_q[SYNC_STAGES-2:0], osc_in};
   assign prev_d   = sync_q[SYNC_STAGES-1];
   assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

   // Count including this cycle's edge; an edge arriving at the
   // ceiling is dropped and flagged.
   always_comb begin
      edge_nxt = edge_q;
      ovf_nxt  = ovf_q;
      if (edge_det) begin
         if (edge_q == CNT_MAX) ovf_nxt = 1'b1;
         else                   edge_nxt = edge_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      gate_d  = gate_q;
      edge_d  = edge_q;
      ovf_d   = ovf_q;
      res_d   = res_q;
      rovf_d  = rovf_q;
      lost_d  = lost_q;
      valid_d = valid_q;

      if (valid_q && result_ready) begin
         valid_d = 1'b0;
         lost_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = GATE;
               gate_d  = '0;
               edge_d  = '0;
               ovf_d   = 1'b0;
            end
         end
         GATE: begin
            // A completed window publishes even if en falls on its
            // last cycle; back-to-back gates restart with no gap.
            if (gate_q == GATE_LAST) begin
               res_d   = edge_nxt;
               rovf_d  = ovf_nxt;
               valid_d = 1'b1;
               lost_d  = valid_q & ~result_ready;
               gate_d  = '0;
               edge_d  = '0;
               ovf_d   = 1'b0;
               state_d = en ? GATE : IDLE;
            end else if (!en) begin
               state_d = IDLE;
            end else begin
               gate_d = gate_q + 1'b1;
               edge_d = edge_nxt;
               ovf_d  = ovf_nxt;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         sync_q  <= '0;
         prev_q  <= 1'b0;
         gate_q  <= '0;
         edge_q  <= '0;
         ovf_q   <= 1'b0;
         res_q   <= '0;
         rovf_q  <= 1'b0;
         lost_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         gate_q  <= gate_d;
         edge_q  <= edge_d;
         ovf_q   <= ovf_d;
         res_q   <= res_d;
         rovf_q  <= rovf_d;
         lost_q  <= lost_d;
         valid_q <= valid_d;
      end
   end

   assign result       = res_q;
   assign result_ovf   = rovf_q;
   assign result_lost  = lost_q;
   assign result_valid = valid_q;
   assign busy         = (state_q == GATE);

`ifdef FREQ_METER_STALL_EN
   localparam int SW = $clog2(STALL_CYCLES + 1);
   localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES);

   logic [SW-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (edge_det)                stall_d = '0;
      else if (stall_q != STALL_MAX) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) stall_q <= '0;
      else         stall_q <= stall_d;
   end

   assign stalled = (stall_q == STALL_MAX);
`else
   assign stalled = 1'b0;
`endif

endmodule
